// File: rtl/mem_types_pkg.sv
// Shared line/beat types and adapter FSM encoding for the
// cache-to-bmem burst adapter.
package mem_types_pkg;

    localparam int BEAT_W         = 64;
    localparam int BEATS_PER_LINE = 4;
    localparam int LINE_W         = BEAT_W * BEATS_PER_LINE;

    localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_LINE - 1);

    typedef logic [255:0] line_t;
    typedef logic [63:0]  beat_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR,
        ST_DONE
    } adapter_state_t;

    function automatic logic [31:0] line_align(input logic [31:0] a);
        return a & ~32'h1F;
    endfunction

endpackage

// File: rtl/line_shift_reg.sv
// One line of storage with beat-indexed write and read, used both to
// assemble read bursts and to serialise write lines.
module line_shift_reg
    import mem_types_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  line_t      line_i,
    input  logic       beat_we_i,
    input  logic [1:0] idx_i,
    input  beat_t      beat_i,
    output line_t      line_o,
    output beat_t      beat_o
);

    line_t line_q, line_d;

    always_comb begin
        line_d = line_q;
        if (load_i) begin
            line_d = line_i;
        end else if (beat_we_i) begin
            line_d[idx_i*BEAT_W +: BEAT_W] = beat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_o = line_q;
    assign beat_o = line_q[idx_i*BEAT_W +: BEAT_W];

endmodule

// File: rtl/cacheline_adapter.sv
// Converts 256-bit cache line reads/writes into 4 x 64-bit bmem bursts,
// one line transaction in flight at a time.
module cacheline_adapter
    import mem_types_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  dfp_addr,
    input  logic         dfp_read,
    input  logic         dfp_write,
    input  logic [255:0] dfp_wdata,
    output logic [255:0] dfp_rdata,
    output logic         dfp_resp,
    output logic [31:0]  bmem_addr,
    output logic         bmem_read,
    output logic         bmem_write,
    output logic [63:0]  bmem_wdata,
    input  logic         bmem_ready,
    input  logic [31:0]  bmem_raddr,
    input  logic [63:0]  bmem_rdata,
    input  logic         bmem_rvalid
);

    adapter_state_t state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [31:0]    addr_q, addr_d;
    line_t          rdata_q, rdata_d;
    logic           gap_q, gap_d;

    logic  sr_load;
    logic  sr_we;
    line_t sr_line;
    beat_t sr_beat;

    line_shift_reg u_line (
        .clk       (clk),
        .rst       (rst),
        .load_i    (sr_load),
        .line_i    (dfp_wdata),
        .beat_we_i (sr_we),
        .idx_i     (cnt_q),
        .beat_i    (bmem_rdata),
        .line_o    (sr_line),
        .beat_o    (sr_beat)
    );

    logic beat_hit;
    assign beat_hit = bmem_rvalid && (bmem_raddr == addr_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rdata_d    = rdata_q;
        gap_d      = 1'b0;
        sr_load    = 1'b0;
        sr_we      = 1'b0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        dfp_resp   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // gap_q masks the request still held in the cycle after resp
                if (!gap_q && dfp_read) begin
                    addr_d  = line_align(dfp_addr);
                    state_d = ST_RD_REQ;
                end else if (!gap_q && dfp_write) begin
                    addr_d  = line_align(dfp_addr);
                    sr_load = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_WR;
                end
            end
            ST_RD_REQ: begin
                bmem_read = 1'b1;
                if (bmem_ready) begin
                    cnt_d   = '0;
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (beat_hit) begin
                    sr_we = 1'b1;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LAST_BEAT) begin
                        rdata_d = sr_line;
                        rdata_d[LINE_W-1 -: BEAT_W] = bmem_rdata;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WR: begin
                bmem_write = 1'b1;
                if (bmem_ready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                dfp_resp = 1'b1;
                gap_d    = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            gap_q   <= gap_d;
        end
    end

    assign dfp_rdata  = rdata_q;
    assign bmem_addr  = addr_q;
    assign bmem_wdata = (state_q == ST_WR) ? sr_beat : '0;

    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_IDLE && !gap_q) begin
            assert (!(dfp_read && dfp_write))
            else $warning("dfp_read and dfp_write both high; read taken");
        end
    end

endmodule
